// File: rtl/fp16_pkg.sv
// Shared definitions for the fp16 conversion blocks.
// Holds the binary16 field geometry, integer saturation limits, rounding-mode
// encodings and the pipeline payload structs used by fp16_to_int16_pipe.
package fp16_pkg;

  localparam int unsigned FP16_EXP_W  = 5;
  localparam int unsigned FP16_MANT_W = 10;
  localparam int unsigned FP16_BIAS   = 15;

  localparam logic [15:0] INT16_MAX = 16'h7FFF;
  localparam logic [15:0] INT16_MIN = 16'h8000;

  localparam logic ROUND_RNE   = 1'b0;
  localparam logic ROUND_TRUNC = 1'b1;

  // Stage-1 payload: rounded magnitude plus the exception classification.
  typedef struct packed {
    logic        sign;
    logic [16:0] mag;
    logic        inexact;
    logic        invalid;
    logic        inf;
  } s1_t;

  // Stage-2 payload: final integer and flags as presented on the outputs.
  typedef struct packed {
    logic [15:0] int_val;
    logic        inexact;
    logic        overflow;
    logic        invalid;
  } s2_t;

  // Unbiased exponent of a binary16 exponent field, as a signed value.
  function automatic logic signed [5:0] fp16_unbias(input logic [FP16_EXP_W-1:0] exp);
    return $signed({1'b0, exp}) - $signed(6'(FP16_BIAS));
  endfunction

endpackage

// File: rtl/fp16_align_round.sv
// Combinational alignment and rounding of an fp16 significand to an integer
// magnitude.
//   sig_i        : 11-bit significand {1, mant}
//   k_i          : unbiased exponent (signed)
//   round_mode_i : ROUND_RNE or ROUND_TRUNC
//   mag_o        : 17-bit rounded integer magnitude
//   inexact_o    : bits were discarded during alignment
module fp16_align_round
  import fp16_pkg::*;
(
  input  logic [10:0]       sig_i,
  input  logic signed [5:0] k_i,
  input  logic              round_mode_i,
  output logic [16:0]       mag_o,
  output logic              inexact_o
);

  logic [3:0]  rsh;
  logic [2:0]  lsh;
  logic [21:0] ext;
  logic [10:0] trunc;
  logic        guard;
  logic        sticky;
  logic        round_up;

  always_comb begin
    rsh      = '0;
    lsh      = '0;
    ext      = '0;
    trunc    = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    round_up = 1'b0;
    mag_o    = '0;
    if (k_i > 6'sd10) begin
      // Left shift: value is an exact integer.
      lsh   = 3'(k_i - 6'sd10);
      mag_o = {6'b0, sig_i} << lsh;
    end else begin
      if (k_i < -6'sd1) begin
        // Entire value below 0.5: guard is clear, nonzero residue is sticky.
        sticky = 1'b1;
      end else begin
        // Shift 0..11; the low 11 bits of ext collect what was shifted out.
        rsh    = 4'(6'sd10 - k_i);
        ext    = {sig_i, 11'b0} >> rsh;
        trunc  = ext[21:11];
        guard  = ext[10];
        sticky = |ext[9:0];
      end
      round_up = (round_mode_i == ROUND_RNE) && guard && (sticky || trunc[0]);
      mag_o    = {6'b0, trunc} + {16'b0, round_up};
    end
    inexact_o = guard | sticky;
  end

endmodule

// File: rtl/fp16_to_int16_pipe.sv
// Two-stage pipelined binary16 -> int16 converter with valid/ready on both sides.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake, fp_in = {sign, exp[4:0], mant[9:0]}
//   out_valid/out_ready : output handshake
//   int_out           : saturated two's-complement result
//   flag_inexact/flag_overflow/flag_invalid : exception flags for int_out
// Stage 1 registers the aligned, rounded magnitude; saturation and negation
// sit between stage 1 and stage 2.
module fp16_to_int16_pipe
  import fp16_pkg::*;
#(
  parameter int unsigned ROUND_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] fp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] int_out,
  output logic        flag_inexact,
  output logic        flag_overflow,
  output logic        flag_invalid
);

  localparam logic RoundMode = (ROUND_MODE == 1) ? ROUND_TRUNC : ROUND_RNE;

  logic                  s1_valid_q, s1_valid_d;
  s1_t                   s1_q, s1_d;
  logic                  out_valid_q, out_valid_d;
  s2_t                   out_q, out_d;

  logic                  s1_load;
  logic                  s2_load;
  logic [FP16_EXP_W-1:0] exp_f;
  logic [FP16_MANT_W-1:0] mant_f;
  logic [16:0]           align_mag;
  logic                  align_inexact;
  s1_t                   dec;
  s2_t                   sat;

  assign exp_f  = fp_in[14:10];
  assign mant_f = fp_in[9:0];

  fp16_align_round u_align_round (
    .sig_i        ({1'b1, mant_f}),
    .k_i          (fp16_unbias(exp_f)),
    .round_mode_i (RoundMode),
    .mag_o        (align_mag),
    .inexact_o    (align_inexact)
  );

  // Decode / classify the incoming operand.
  always_comb begin
    dec      = '0;
    dec.sign = fp_in[15];
    if (exp_f == '0) begin
      dec.inexact = |mant_f;
    end else if (exp_f == '1) begin
      dec.invalid = |mant_f;
      dec.inf     = ~|mant_f;
    end else begin
      dec.mag     = align_mag;
      dec.inexact = align_inexact;
    end
  end

  // Saturation and sign application on the stage-1 contents.
  always_comb begin
    sat = '0;
    if (s1_q.invalid) begin
      sat.invalid = 1'b1;
    end else if (s1_q.inf ||
                 (!s1_q.sign && (s1_q.mag > 17'd32767)) ||
                 (s1_q.sign && (s1_q.mag > 17'd32768))) begin
      sat.int_val  = s1_q.sign ? INT16_MIN : INT16_MAX;
      sat.overflow = 1'b1;
      sat.inexact  = 1'b1;
    end else begin
      // mag <= 32768 here, so its low 16 bits carry the full value.
      sat.int_val = s1_q.sign ? 16'(16'd0 - s1_q.mag[15:0]) : s1_q.mag[15:0];
      sat.inexact = s1_q.inexact;
    end
  end

  // Handshake: each stage advances when the stage ahead is free or draining.
  always_comb begin
    s2_load     = !out_valid_q || out_ready;
    s1_load     = !s1_valid_q || s2_load;
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = dec;
      end
    end
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      // Outputs keep their last value when nothing new arrives.
      if (s1_valid_q) begin
        out_d = sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign in_ready      = s1_load;
  assign out_valid     = out_valid_q;
  assign int_out       = out_q.int_val;
  assign flag_inexact  = out_q.inexact;
  assign flag_overflow = out_q.overflow;
  assign flag_invalid  = out_q.invalid;

endmodule

// File: tb/tb_fp16_to_int16_pipe.sv
`timescale 1ns/1ps
// Bench for fp16_to_int16_pipe: one RNE and one truncating instance share
// the input stream and out_ready; results are checked against a real-valued
// reference model through an in-order scoreboard.
module tb_fp16_to_int16_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] fp_in = '0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, fi0, fo0, fv0;
  logic [15:0] int_out0;
  logic        in_ready1, out_valid1, fi1, fo1, fv1;
  logic [15:0] int_out1;

  always #5 clk = ~clk;

  fp16_to_int16_pipe #(.ROUND_MODE(0)) u_dut_rne (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready0),
    .fp_in         (fp_in),
    .out_valid     (out_valid0),
    .out_ready     (out_ready),
    .int_out       (int_out0),
    .flag_inexact  (fi0),
    .flag_overflow (fo0),
    .flag_invalid  (fv0)
  );

  fp16_to_int16_pipe #(.ROUND_MODE(1)) u_dut_trunc (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready1),
    .fp_in         (fp_in),
    .out_valid     (out_valid1),
    .out_ready     (out_ready),
    .int_out       (int_out1),
    .flag_inexact  (fi1),
    .flag_overflow (fo1),
    .flag_invalid  (fv1)
  );

  typedef struct {
    logic [18:0] e0;
    logic [18:0] e1;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  bit          held_vld = 1'b0;
  logic [15:0] held_val = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: value as a real number, rounded and saturated arithmetically.
  // Returns {int16, inexact, overflow, invalid}.
  function automatic logic [18:0] ref_conv(input logic [15:0] x, input bit trunc);
    int          e;
    int          m;
    real         r;
    real         frac;
    longint      mag;
    logic [15:0] v;
    e = int'(x[14:10]);
    m = int'(x[9:0]);
    if (e == 31) begin
      if (m != 0) return 19'b001;
      return {(x[15] ? 16'h8000 : 16'h7FFF), 3'b110};
    end
    if (e == 0) return {16'h0000, (m != 0), 2'b00};
    r = 1.0 + real'(m) / 1024.0;
    for (int i = 0; i < e - 15; i++) r = r * 2.0;
    for (int i = 0; i < 15 - e; i++) r = r / 2.0;
    mag  = longint'($floor(r));
    frac = r - $floor(r);
    if (!trunc && (frac > 0.5 || (frac == 0.5 && (mag % 2) == 1))) mag++;
    if (!x[15] && mag > 32767) return {16'h7FFF, 3'b110};
    if (x[15] && mag > 32768) return {16'h8000, 3'b110};
    v = x[15] ? 16'(-mag) : 16'(mag);
    return {v, (frac != 0.0), 2'b00};
  endfunction

  // One clock cycle: drive inputs on the falling edge, then check and update
  // the scoreboard for the transfers that the next rising edge will perform.
  task automatic step(input logic v, input logic [15:0] d, input logic ordy, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    fp_in     = d;
    out_ready = ordy;
    #1;
    cyc++;
    acc = 1'b0;
    check_eq("in_ready", {31'b0, in_ready0}, {31'b0, !(q.size() == 2 && !ordy)});
    check_eq("in_ready_trunc", {31'b0, in_ready1}, {31'b0, !(q.size() == 2 && !ordy)});
    if (held_vld) begin
      check_eq("stall_valid", {31'b0, out_valid0}, 32'd1);
      check_eq("stall_data", {16'b0, int_out0}, {16'b0, held_val});
    end
    if (out_valid0 && ordy) begin
      if (q.size() == 0) begin
        check_eq("spurious_out", {31'b0, out_valid0}, 32'd0);
      end else begin
        e = q.pop_front();
        check_eq("result_rne", {13'b0, int_out0, fi0, fo0, fv0}, {13'b0, e.e0});
        check_eq("result_trunc", {13'b0, int_out1, fi1, fo1, fv1}, {13'b0, e.e1});
        check_eq("valid_trunc", {31'b0, out_valid1}, 32'd1);
        if (lat_chk) check_eq("latency", cyc - e.cyc, 32'd2);
      end
    end
    held_vld = out_valid0 && !ordy;
    held_val = int_out0;
    if (v && in_ready0) begin
      e.e0  = ref_conv(d, 1'b0);
      e.e1  = ref_conv(d, 1'b1);
      e.cyc = cyc;
      q.push_back(e);
      acc = 1'b1;
    end
  endtask

  task automatic send(input logic [15:0] d, input logic ordy);
    logic acc;
    for (int t = 0; t < 50; t++) begin
      step(1'b1, d, ordy, acc);
      if (acc) return;
    end
    check_eq("send_timeout", {31'b0, in_ready0}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_out_valid", {31'b0, out_valid0}, 32'd0);
    check_eq("rst_int_out", {16'b0, int_out0}, 32'd0);
    check_eq("rst_flags", {29'b0, fi0, fo0, fv0}, 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready0}, 32'd1);
    check_eq("rst_trunc", {15'b0, out_valid1, int_out1}, 32'd0);
    q.delete();
    held_vld = 1'b0;
  endtask

  logic [15:0] directed[] = '{
    16'h3C00, 16'hC000, 16'h0000, 16'h8000, 16'h3800, 16'h3E00, 16'h4100, 16'h0001,
    16'hBE00, 16'h7800, 16'hF800, 16'h7BFF, 16'hFC00, 16'h7E00, 16'h7C00, 16'h5640,
    16'h3A00, 16'hC100, 16'h77FF, 16'h0400
  };

  initial begin
    logic acc;
    int   sent;
    do_reset();

    // Directed values, back to back with out_ready high.
    lat_chk = 1'b1;
    foreach (directed[i]) send(directed[i], 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, acc);
    check_eq("directed_drain", q.size(), 32'd0);

    // Random values under random backpressure.
    lat_chk = 1'b0;
    sent = 0;
    for (int t = 0; t < 600 && sent < 24; t++) begin
      step(($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)), acc);
      if (acc) sent++;
    end
    check_eq("random_sent", sent, 32'd24);
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1, acc);
    check_eq("random_drain", q.size(), 32'd0);

    // Fill both stages, confirm in_ready drops, then reset mid-stream.
    step(1'b1, 16'h4500, 1'b0, acc);
    step(1'b1, 16'hC500, 1'b0, acc);
    step(1'b1, 16'h4600, 1'b0, acc);
    check_eq("full_depth", q.size(), 32'd2);
    do_reset();
    lat_chk = 1'b1;
    send(16'h3C00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, acc);
    check_eq("post_reset_drain", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
